// File: rtl/imm_pkg.sv
// Shared types for the skylark-v immediate-extension stage: format codes and
// the per-entry control flags stored alongside each extended immediate.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_J    = 3'd3,
        IMM_U    = 3'd4,
        IMM_Z    = 3'd5,
        IMM_RSV6 = 3'd6,
        IMM_RSV7 = 3'd7
    } imm_fmt_e;

    // Lowest instruction bit carried into the stage; bits [6:0] are the opcode.
    localparam int INS_LO = 7;

    typedef struct packed {
        logic valid;
        logic illegal;
    } entry_ctrl_t;

endpackage

// File: rtl/imm_extend_comb.sv
// Combinational immediate extraction and sign/zero extension to XLEN from
// instruction bits [31:7], selected by format code.
module imm_extend_comb
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  imm_fmt_e             fmt,
    input  logic [31:INS_LO]     bits,
    output logic [XLEN-1:0]      imm,
    output logic                 illegal
);

    logic signed [31:0] w_imm32;

    // Every 32-bit pattern already carries its final sign in bit 31 (zero for
    // zimm and reserved codes), so a signed resize covers XLEN = 32 and 64.
    always_comb begin
        w_imm32 = '0;
        illegal = 1'b0;
        case (fmt)
            IMM_I: w_imm32 = {{20{bits[31]}}, bits[31:20]};
            IMM_S: w_imm32 = {{20{bits[31]}}, bits[31:25], bits[11:7]};
            IMM_B: w_imm32 = {{19{bits[31]}}, bits[31], bits[7], bits[30:25], bits[11:8], 1'b0};
            IMM_J: w_imm32 = {{11{bits[31]}}, bits[31], bits[19:12], bits[20], bits[30:21], 1'b0};
            IMM_U: w_imm32 = {bits[31:12], 12'b0};
            IMM_Z: w_imm32 = {27'b0, bits[19:15]};
            default: illegal = 1'b1;
        endcase
    end

    assign imm = XLEN'(w_imm32);

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate-extension stage with a 2-entry skid buffer: head drives
// the outputs, skid absorbs one item while the head is stalled.
module imm_extend_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [24:0]       in_bits,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_imm,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        entry_ctrl_t      ctl;
    } entry_t;

    entry_t            r_head;
    entry_t            r_skid;
    entry_t            w_new;
    logic [XLEN-1:0]   w_imm;
    logic              w_illegal;
    logic              w_push;
    logic              w_pop;

    imm_extend_comb #(
        .XLEN (XLEN)
    ) u_ext (
        .fmt     (imm_fmt_e'(in_fmt)),
        .bits    (in_bits),
        .imm     (w_imm),
        .illegal (w_illegal)
    );

    assign w_new     = '{imm: w_imm, tag: in_tag, ctl: '{valid: 1'b1, illegal: w_illegal}};
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = r_head.ctl.valid && out_ready;

    // in_ready comes straight from the skid valid flop, never from out_ready.
    assign in_ready  = !r_skid.ctl.valid;

    // Stage boundary: extended entries registered into head/skid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_skid <= '0;
        end else if (flush) begin
            r_head <= '0;
            r_skid <= '0;
        end else if (!r_head.ctl.valid || w_pop) begin
            if (r_skid.ctl.valid) begin
                r_head <= r_skid;
                r_skid <= w_push ? w_new : '0;
            end else begin
                r_head <= w_push ? w_new : '0;
            end
        end else if (w_push) begin
            r_skid <= w_new;
        end
    end

    assign out_valid   = r_head.ctl.valid;
    assign out_imm     = r_head.imm;
    assign out_tag     = r_head.tag;
    assign out_illegal = r_head.ctl.illegal;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Scoreboard bench driving XLEN=32 and XLEN=64 instances with shared stimulus.
module tb_imm_extend_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_fmt = 3'd0;
    logic [24:0] in_bits = '0;
    logic [7:0]  in_tag = '0;
    logic        out_ready = 1'b1;

    logic        rdy32, vld32, ill32;
    logic [31:0] imm32;
    logic [7:0]  tag32;
    logic        rdy64, vld64, ill64;
    logic [63:0] imm64;
    logic [7:0]  tag64;

    imm_extend_stage #(.XLEN(32), .TAG_W(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_fmt(in_fmt),
        .in_bits(in_bits), .in_tag(in_tag),
        .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32),
        .out_tag(tag32), .out_illegal(ill32)
    );

    imm_extend_stage #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_fmt(in_fmt),
        .in_bits(in_bits), .in_tag(in_tag),
        .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64),
        .out_tag(tag64), .out_illegal(ill64)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] imm;
        logic [7:0]  tag;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        accepted = 1'b0;
    logic        rand_ready = 1'b0;
    logic        hold_chk = 1'b0;
    logic [31:0] h_imm;
    logic [7:0]  h_tag;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] f, input logic [24:0] b);
        logic [31:7] ins;
        logic [63:0] r;
        ins = b;
        case (f)
            3'd0: r = {{52{ins[31]}}, ins[31:20]};
            3'd1: r = {{52{ins[31]}}, ins[31:25], ins[11:7]};
            3'd2: r = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            3'd3: r = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            3'd4: r = {{32{ins[31]}}, ins[31:12], 12'b0};
            3'd5: r = {59'b0, ins[19:15]};
            default: r = '0;
        endcase
        return r;
    endfunction

    // One clock: inputs are set at posedge+1, outputs sampled at negedge.
    task automatic cycle();
        exp_t e;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        accepted = 1'b0;
        if (hold_chk) begin
            chk("hold_vld", 64'(vld32), 64'd1);
            chk("hold_imm", 64'(imm32), 64'(h_imm));
            chk("hold_tag", 64'(tag32), 64'(h_tag));
        end
        hold_chk = vld32 && !out_ready && !flush;
        h_imm = imm32;
        h_tag = tag32;
        if (flush) begin
            q.delete();
        end else begin
            if (vld32 && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 64'(vld32), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("imm32", 64'(imm32), 64'(e.imm[31:0]));
                    chk("tag32", 64'(tag32), 64'(e.tag));
                    chk("ill32", 64'(ill32), 64'(e.ill));
                    chk("vld64", 64'(vld64), 64'd1);
                    chk("imm64", imm64, e.imm);
                    chk("tag64", 64'(tag64), 64'(e.tag));
                    chk("ill64", 64'(ill64), 64'(e.ill));
                end
            end
            if (in_valid && rdy32) begin
                e.imm = model(in_fmt, in_bits);
                e.tag = in_tag;
                e.ill = in_fmt[2] & in_fmt[1];
                q.push_back(e);
                accepted = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] f, input logic [31:0] ins, input logic [7:0] t);
        in_valid = 1'b1;
        in_fmt   = f;
        in_bits  = ins[31:7];
        in_tag   = t;
        for (int k = 0; k < 50; k++) begin
            cycle();
            if (accepted) break;
        end
        if (!accepted) chk("send_timeout", 64'(accepted), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        in_valid   = 1'b0;
        for (int k = 0; k < 20 && q.size() != 0; k++) cycle();
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #3 rst_n = 1'b0;
        #1;
        chk("rst_vld", 64'(vld32), 64'd0);
        chk("rst_rdy", 64'(rdy32), 64'd1);
        chk("rst_imm", imm64, 64'd0);
        chk("rst_tag", 64'(tag32), 64'd0);
        chk("rst_ill", 64'(ill64), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single I-type item: one-cycle latency, valid for exactly one cycle.
        out_ready = 1'b1;
        send(3'd0, 32'h00E0_0000, 8'h01);
        chk("t1_vld", 64'(vld32), 64'd1);
        chk("t1_imm", 64'(imm32), 64'h0000_000E);
        cycle();
        chk("t1_vld_gone", 64'(vld32), 64'd0);

        // Directed formats through the scoreboard, plus literal 64-bit values.
        send(3'd0, 32'hFF60_0000, 8'h02);
        chk("t2_i64", imm64, 64'hFFFF_FFFF_FFFF_FFF6);
        send(3'd4, 32'h8000_1000, 8'h03);
        chk("t2_u64", imm64, 64'hFFFF_FFFF_8000_1000);
        chk("t2_u32", 64'(imm32), 64'h8000_1000);
        send(3'd1, 32'h0400_0400, 8'h04);
        chk("t2_s", imm64, 64'h48);
        send(3'd2, 32'h0200_0800, 8'h05);
        chk("t3_b", imm64, 64'h30);
        send(3'd3, 32'h01C0_0000, 8'h06);
        chk("t3_j", imm64, 64'h1C);
        send(3'd5, 32'hFFFF_8000, 8'h07);
        chk("t3_z", imm64, 64'h1F);
        send(3'd6, 32'hDEAD_BEEF, 8'h08);
        chk("t3_rsv_imm", imm64, 64'd0);
        chk("t3_rsv_ill", 64'(ill32), 64'd1);
        drain();

        // Back-pressure: A and B buffered, C held off.
        out_ready = 1'b0;
        send(3'd0, 32'h1230_0000, 8'hA0);
        send(3'd1, 32'h8000_0F80, 8'hB0);
        chk("t4_rdy_low", 64'(rdy32), 64'd0);
        in_valid = 1'b1; in_fmt = 3'd2; in_bits = 25'h1AB_CDEF; in_tag = 8'hC0;
        cycle();
        chk("t4_c_held1", 64'(accepted), 64'd0);
        cycle();
        chk("t4_c_held2", 64'(accepted), 64'd0);
        chk("t4_head_a", 64'(tag32), 64'hA0);
        out_ready = 1'b1;
        for (int k = 0; k < 10 && !accepted; k++) cycle();
        chk("t4_c_acc", 64'(accepted), 64'd1);
        in_valid = 1'b0;
        drain();
        chk("t4_rdy_back", 64'(rdy32), 64'd1);

        // Flush with two entries buffered and D offered in the same cycle.
        out_ready = 1'b0;
        send(3'd0, 32'h0010_0000, 8'hE1);
        send(3'd0, 32'h0020_0000, 8'hE2);
        flush = 1'b1;
        in_valid = 1'b1; in_fmt = 3'd0; in_bits = 25'h0; in_tag = 8'hDD;
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t5_vld", 64'(vld32), 64'd0);
        chk("t5_vld64", 64'(vld64), 64'd0);
        chk("t5_rdy", 64'(rdy32), 64'd1);
        out_ready = 1'b1;
        repeat (3) cycle();
        chk("t5_q_empty", 64'(q.size()), 64'd0);

        // Random traffic with random back-pressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 150; n++)
            send(3'($urandom_range(0, 7)), $urandom, 8'($urandom));
        drain();

        // Asynchronous reset in the middle of a burst.
        rand_ready = 1'b1;
        for (int n = 0; n < 6; n++)
            send(3'($urandom_range(0, 5)), $urandom, 8'(8'h40 + n));
        in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_vld", 64'(vld32), 64'd0);
        chk("t6_rdy", 64'(rdy32), 64'd1);
        chk("t6_imm", 64'(imm32), 64'd0);
        chk("t6_tag", 64'(tag64), 64'd0);
        chk("t6_ill", 64'(ill32), 64'd0);
        in_valid = 1'b0;
        rand_ready = 1'b0;
        q.delete();
        hold_chk = 1'b0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_idle", 64'(vld32), 64'd0);
        out_ready = 1'b1;
        send(3'd0, 32'h1230_0000, 8'h5A);
        chk("t6_first_vld", 64'(vld32), 64'd1);
        chk("t6_first_tag", 64'(tag32), 64'h5A);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
